// File: rtl/tx_mac_pkg.sv
// Shared types, constants and CRC-32 helper for the Ethernet TX framer.
package tx_mac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        DATA,
        PAD,
        FCS,
        IFG
    } tx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int          PREAMBLE_LEN  = 7;
    localparam int          MIN_FRAME     = 60;
    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    // Reflected (LSB-first) CRC-32 update over one byte.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        logic [31:0] p;
        p = reflect32(CRC_POLY);
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ p) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/tx_mac_framer_fifo.sv
// Show-ahead synchronous FIFO with fill level, used as the whole-frame buffer.
module tx_mac_sync_fifo #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 19,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic [AW:0]      usedw_o
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             wr_ok, rd_ok;

    assign full_o    = (cnt_q == DEPTH_W);
    assign usedw_o   = cnt_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ok    = wr_en_i && !full_o;
        rd_ok    = rd_en_i && (cnt_q != '0);
        wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/tx_mac_framer.sv
// Ethernet TX framer: whole-frame buffer, preamble/SFD, FCS and IFG onto GMII.
// Optional minimum-length zero padding is enabled by defining TX_MAC_PAD_EN.
module tx_mac_framer
    import tx_mac_pkg::*;
#(
    parameter int FIFO_DEPTH = 1024,
    parameter int IFG_BYTES  = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] din,
    input  logic        din_sop,
    input  logic        din_eop,
    input  logic        din_vld,
    input  logic        din_mty,
    output logic        din_rdy,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(FIFO_DEPTH);

    logic [18:0] rd_data;
    logic        fifo_full;
    logic [AW:0] usedw;
    logic        pop;

    tx_mac_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (19)
    ) u_fifo (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (din_vld),
        .wr_data_i ({din_sop, din_eop, din_mty, din}),
        .rd_en_i   (pop),
        .rd_data_o (rd_data),
        .full_o    (fifo_full),
        .usedw_o   (usedw)
    );

    logic        head_eop, head_mty;
    logic [15:0] head_word;
    logic        unused_sop;

    // A mid-frame sop is sent as ordinary data, so the flag is never consulted.
    assign unused_sop = rd_data[18];
    assign head_eop   = rd_data[17];
    assign head_mty   = rd_data[16];
    assign head_word  = rd_data[15:0];

    logic [AW:0] frame_cnt_q, frame_cnt_d;
    logic        rdy_q, rdy_d;
    logic        fr_inc, fr_dec;
    logic [AW:0] free_cnt;

    always_comb begin
        fr_inc      = din_vld && din_eop && !fifo_full;
        fr_dec      = pop && head_eop;
        frame_cnt_d = frame_cnt_q;
        if (fr_inc && !fr_dec) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end else if (fr_dec && !fr_inc) begin
            frame_cnt_d = frame_cnt_q - 1'b1;
        end
        free_cnt = DEPTH_W - usedw;
        rdy_d    = (free_cnt > (AW+1)'(2));
    end

    tx_state_e   state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        phase_q, phase_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  txd_q, txd_d;
    logic        en_q, en_d;
    logic [7:0]  byte_sel;
    logic        last;
    logic [31:0] fcs;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        byte_cnt_d = byte_cnt_q;
        crc_d      = crc_q;
        txd_d      = 8'h00;
        en_d       = 1'b0;
        pop        = 1'b0;
        last       = 1'b0;
        byte_sel   = phase_q ? head_word[7:0] : head_word[15:8];
        fcs        = ~crc_q;
        unique case (state_q)
            // The first preamble byte leaves straight from IDLE.
            IDLE: begin
                if (frame_cnt_q != '0) begin
                    txd_d   = PREAMBLE_BYTE;
                    en_d    = 1'b1;
                    cnt_d   = 8'd1;
                    state_d = PRE;
                end
            end
            PRE: begin
                txd_d = PREAMBLE_BYTE;
                en_d  = 1'b1;
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'(PREAMBLE_LEN - 1)) begin
                    state_d = SFD;
                end
            end
            SFD: begin
                txd_d      = SFD_BYTE;
                en_d       = 1'b1;
                byte_cnt_d = '0;
                crc_d      = CRC_INIT;
                phase_d    = 1'b0;
                state_d    = DATA;
            end
            DATA: begin
                txd_d      = byte_sel;
                en_d       = 1'b1;
                crc_d      = crc32_byte(crc_q, byte_sel);
                byte_cnt_d = byte_cnt_q + 11'd1;
                if (!phase_q) begin
                    if (head_eop && head_mty) begin
                        pop  = 1'b1;
                        last = 1'b1;
                    end else begin
                        phase_d = 1'b1;
                    end
                end else begin
                    pop     = 1'b1;
                    phase_d = 1'b0;
                    last    = head_eop;
                end
                if (last) begin
                    cnt_d   = '0;
`ifdef TX_MAC_PAD_EN
                    state_d = (byte_cnt_d < 11'(MIN_FRAME)) ? PAD : FCS;
`else
                    state_d = FCS;
`endif
                end
            end
`ifdef TX_MAC_PAD_EN
            PAD: begin
                txd_d      = 8'h00;
                en_d       = 1'b1;
                crc_d      = crc32_byte(crc_q, 8'h00);
                byte_cnt_d = byte_cnt_q + 11'd1;
                if (byte_cnt_d == 11'(MIN_FRAME)) begin
                    cnt_d   = '0;
                    state_d = FCS;
                end
            end
`endif
            FCS: begin
                txd_d = fcs[{cnt_q[1:0], 3'b000} +: 8];
                en_d  = 1'b1;
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'd3) begin
                    cnt_d   = '0;
                    state_d = IFG;
                end
            end
            IFG: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'(IFG_BYTES - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            phase_q     <= 1'b0;
            byte_cnt_q  <= '0;
            crc_q       <= CRC_INIT;
            txd_q       <= 8'h00;
            en_q        <= 1'b0;
            frame_cnt_q <= '0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            byte_cnt_q  <= byte_cnt_d;
            crc_q       <= crc_d;
            txd_q       <= txd_d;
            en_q        <= en_d;
            frame_cnt_q <= frame_cnt_d;
            rdy_q       <= rdy_d;
        end
    end

    assign din_rdy    = rdy_q;
    assign gmii_txd   = txd_q;
    assign gmii_tx_en = en_q;

endmodule

// File: tb/tb_tx_mac_framer.sv
// Randomised self-checking bench for tx_mac_framer against a byte-stream model.
module tb_tx_mac_framer;

    localparam int DEPTH = 1024;
    localparam int IFGB  = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] din = 16'h0000;
    logic        din_sop = 1'b0;
    logic        din_eop = 1'b0;
    logic        din_vld = 1'b0;
    logic        din_mty = 1'b0;
    logic        din_rdy;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;

    tx_mac_framer #(
        .FIFO_DEPTH (DEPTH),
        .IFG_BYTES  (IFGB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_sop    (din_sop),
        .din_eop    (din_eop),
        .din_vld    (din_vld),
        .din_mty    (din_mty),
        .din_rdy    (din_rdy),
        .gmii_txd   (gmii_txd),
        .gmii_tx_en (gmii_tx_en)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    byte unsigned exp_q[$];
    int           len_q[$];
    byte unsigned frm[$];
    byte unsigned rx[$];

    int cyc = 0;
    int eop_cyc = 0;
    int first_rise = -1;
    int run_len = 0;
    int last_run = 0;
    int gap = 0;
    int last_gap = 0;
    bit in_run = 0;
    bit have_prev = 0;
    bit trunc_chk = 0;
    bit rdy_seen = 0;
    bit saw_rdy_low = 0;

    function automatic logic [31:0] sw_fcs(input byte unsigned b[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    // Expected wire bytes of the frame currently held in frm.
    task automatic push_model();
        byte unsigned body[$];
        logic [31:0]  f;
        body = frm;
`ifdef TX_MAC_PAD_EN
        while (body.size() < 60) body.push_back(8'h00);
`endif
        f = sw_fcs(body);
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        foreach (body[i]) exp_q.push_back(body[i]);
        for (int k = 0; k < 4; k++) exp_q.push_back(f[8*k +: 8]);
        len_q.push_back(body.size() + 12);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (trunc_chk) begin
            chk("rst_trunc_en", {31'h0, gmii_tx_en}, 32'h0);
            trunc_chk = 0;
        end
        if (gmii_tx_en === 1'b1) begin
            if (!in_run) begin
                if (have_prev) chk("ifg_min", {31'h0, gap >= IFGB}, 32'h1);
                last_gap = gap;
                in_run   = 1;
                run_len  = 0;
                rx.delete();
                if (first_rise < 0) first_rise = cyc;
            end
            run_len++;
            rx.push_back(gmii_txd);
            if (exp_q.size() == 0) chk("unexpected_byte", {24'h0, gmii_txd}, 32'hFFFF);
            else chk("txd", {24'h0, gmii_txd}, {24'h0, exp_q.pop_front()});
        end else begin
            if (in_run) begin
                in_run    = 0;
                last_run  = run_len;
                have_prev = 1;
                gap       = 1;
                if (len_q.size() == 0) chk("run_len_unexp", run_len, 0);
                else chk("run_len", run_len, len_q.pop_front());
            end else begin
                gap++;
            end
        end
        if (rst === 1'b1) begin
            if (gmii_tx_en === 1'b1) trunc_chk = 1;
            exp_q.delete();
            len_q.delete();
            in_run    = 0;
            have_prev = 0;
        end else if (din_rdy === 1'b0 && cyc > 5) begin
            saw_rdy_low = 1;
        end
        rdy_seen = (din_rdy === 1'b1);
    end

    task automatic drive_idle();
        @(posedge clk);
        #1;
        din_vld = 0;
        din_sop = 0;
        din_eop = 0;
        din_mty = 0;
    endtask

    // mode 1: ASCII "123..."; mode 0: random payload.
    task automatic send_frame(input int n, input int mode, input bit gaps);
        int nw;
        int w;
        int budget;
        nw = (n + 1) / 2;
        frm.delete();
        for (int i = 0; i < n; i++) begin
            frm.push_back(mode == 1 ? 8'(8'h31 + i) : 8'($urandom));
        end
        w = 0;
        budget = 0;
        while (w < nw && budget < 20000) begin
            @(posedge clk);
            #1;
            budget++;
            if (rdy_seen && !(gaps && $urandom_range(0, 3) == 0)) begin
                din     = {frm[2*w], (2*w+1 < n) ? frm[2*w+1] : 8'h00};
                din_sop = (w == 0);
                din_eop = (w == nw - 1);
                din_mty = (w == nw - 1) && (n % 2 == 1);
                din_vld = 1;
                if (w == nw - 1) begin
                    push_model();
                    eop_cyc = cyc;
                end
                w++;
            end else begin
                din_vld = 0;
                din_sop = 0;
                din_eop = 0;
                din_mty = 0;
            end
        end
        chk("drv_timeout", {31'h0, budget < 20000}, 32'h1);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || in_run) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        chk("drain_timeout", {31'h0, t < 20000}, 32'h1);
        repeat (IFGB + 2) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] ref_crc;
        int t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_en", {31'h0, gmii_tx_en}, 32'h0);
        chk("rst_txd", {24'h0, gmii_txd}, 32'h0);
        chk("rst_rdy", {31'h0, din_rdy}, 32'h0);
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("rdy_release_cyc0", {31'h0, din_rdy}, 32'h0);
        @(negedge clk);
        chk("rdy_release_cyc1", {31'h0, din_rdy}, 32'h1);

        frm.delete();
        for (int i = 0; i < 9; i++) frm.push_back(8'(8'h31 + i));
        ref_crc = sw_fcs(frm);
        chk("model_check_crc", ref_crc, 32'hCBF43926);

        send_frame(9, 1, 0);
        drive_idle();
        wait_done();
        chk("first_byte_latency", first_rise - eop_cyc, 2);
`ifdef TX_MAC_PAD_EN
        chk("len9_padded", last_run, 72);
`else
        chk("len9", last_run, 21);
        chk("fcs9_b0", {24'h0, rx[17]}, 32'h26);
        chk("fcs9_b1", {24'h0, rx[18]}, 32'h39);
        chk("fcs9_b2", {24'h0, rx[19]}, 32'hF4);
        chk("fcs9_b3", {24'h0, rx[20]}, 32'hCB);
        chk("data9_first", {24'h0, rx[8]}, 32'h31);
`endif

        send_frame(64, 0, 0);
        drive_idle();
        wait_done();
        chk("len64", last_run, 76);

        send_frame(42, 0, 1);
        drive_idle();
        wait_done();
`ifdef TX_MAC_PAD_EN
        chk("len42_padded", last_run, 72);
`else
        chk("len42", last_run, 54);
`endif

        send_frame(64, 0, 0);
        send_frame(64, 0, 0);
        drive_idle();
        wait_done();
        chk("b2b_gap", last_gap, IFGB);
        chk("b2b_len", last_run, 76);

        for (int f = 0; f < 20; f++) begin
            send_frame($urandom_range(1, 300), 0, 1);
            if ($urandom_range(0, 1) == 1) drive_idle();
        end
        drive_idle();
        wait_done();

        saw_rdy_low = 0;
        repeat (3) send_frame(1500, 0, 0);
        drive_idle();
        wait_done();
        chk("rdy_backpressure", {31'h0, saw_rdy_low}, 32'h1);
        chk("len1500", last_run, 1512);

        send_frame(100, 0, 0);
        drive_idle();
        t = 0;
        while (!(in_run && run_len >= 28) && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("rst_trigger_timeout", {31'h0, t < 5000}, 32'h1);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        repeat (3) @(posedge clk);
        send_frame(100, 0, 1);
        drive_idle();
        wait_done();
        chk("post_rst_len", last_run, 112);
        chk("queues_empty", exp_q.size() + len_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tx_mac_framer.md
# tx_mac_framer

Ethernet transmit framer sitting directly downstream of the UDP/IP packer. It accepts complete MAC frames (destination MAC through payload) as a 16-bit sop/eop/vld/rdy/mty stream and buffers each frame whole. It then serialises the frame onto an 8-bit GMII-style transmit interface with preamble, SFD, minimum-length padding, CRC-32 FCS and inter-frame gap.

## Interface
- FIFO_DEPTH, 1024: input buffer depth in 16-bit words, power of two; max supported frame = FIFO_DEPTH-4 words.
- IFG_BYTES, 12: idle cycles enforced after each FCS.

- clk  in  1  system clock; one byte per cycle on the output side.
- rst  in  1  reset, synchronous, active-high.
- din  in  16  frame word; high byte [15:8] is transmitted first.
- din_sop  in  1  first word of frame.
- din_eop  in  1  last word of frame.
- din_vld  in  1  word valid; written whenever high, independent of din_rdy.
- din_mty  in  1  valid with din_eop only; 1 = din[7:0] empty (odd-length frame).
- din_rdy  out  1  upstream may issue a word next cycle.
- gmii_txd  out  8  transmit byte.
- gmii_tx_en  out  1  frame byte valid.

## Operation
- Input: {sop,eop,mty,din} is written to the internal FIFO on every din_vld cycle. din_rdy is registered: 1 when free entries > 2, otherwise 0. The 2-entry margin absorbs the upstream one-cycle rdy-to-vld latency. Writing while full is a protocol error; the word is dropped.
- frame_cnt increments when an eop word is written and decrements when an eop word is read. Simultaneous increment and decrement leave it unchanged.
- FSM states are IDLE, PRE, SFD, DATA, PAD, FCS, IFG.
  - IDLE: moves to PRE when frame_cnt > 0.
  - PRE: 7 cycles of 0x55.
  - SFD: 1 cycle of 0xD5.
  - DATA: pops one word per two cycles and sends high byte then low byte. On an eop word with mty=1, the low byte is skipped.
  - After the last byte, go to PAD if byte_cnt < 60 (and padding is enabled), otherwise go to FCS.
  - PAD: send 0x00 until byte_cnt reaches 60.
  - FCS: 4 bytes.
  - IFG: IFG_BYTES cycles with tx_en=0, then return to IDLE.
- byte_cnt is 11 bits and counts DATA and PAD bytes. It clears in SFD.
- CRC-32 uses polynomial 0x04C11DB7, reflected, LSB-first per byte. It is initialised to 0xFFFFFFFF in SFD and updated on every DATA and PAD byte. FCS = ~crc, sent as [7:0], [15:8], [23:16], [31:24].
- A word that has sop=1 in DATA after the first word is not allowed. The block ignores it as sop and transmits it as data.
- Reset behaviour: FIFO flushed, frame_cnt=0, FSM=IDLE, din_rdy=0 (rises 1 cycle after reset release), gmii_txd=0x00, gmii_tx_en=0. Reset mid-frame truncates the frame on the next cycle.

## Timing
- Outputs gmii_txd and gmii_tx_en are registered.
- First 0x55 appears 2 cycles after the eop word is written (1 cycle for frame_cnt, 1 cycle for the output register).
- gmii_tx_en stays high contiguously for 8 + max(N, 60) + 4 cycles, where N is the frame length in bytes. Without padding it is 8 + N + 4 cycles.
- The next frame's preamble starts no earlier than IFG_BYTES + 1 cycles after the last FCS byte.
- Underrun is impossible because the whole frame is buffered before transmission starts.
- FIFO read is show-ahead. The pop happens on the low byte cycle, or on the high byte cycle for an mty=1 eop word.

## Configuration
- TX_MAC_PAD_EN defined: frames under 60 bytes are zero-padded to 60 bytes before the FCS, and the pad bytes are included in the CRC.
- TX_MAC_PAD_EN undefined: the PAD state is compiled out and short frames are sent at their native length followed by the FCS.

## Structure
- Shared package tx_mac_pkg holds:
  - the FSM state enum;
  - constants PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5, PREAMBLE_LEN=7, MIN_FRAME=60, CRC_POLY=0x04C11DB7, CRC_INIT=0xFFFFFFFF;
  - function crc32_byte(crc, byte).
- One sub-module: tx_mac_sync_fifo. It is a 19-bit-wide, FIFO_DEPTH-deep show-ahead FIFO with usedw output, used for din_rdy generation.

## Test plan
- 64-byte frame (32 words, mty=0) -> tx_en high for 76 cycles; bytes: 7×0x55, 0xD5, payload in order, 4 FCS bytes; FCS matches the software model.
- With TX_MAC_PAD_EN undefined: 9-byte frame "123456789" (5 words, last word 0x3900 with mty=1) -> 9 data bytes then FCS 0x26, 0x39, 0xF4, 0xCB.
- With TX_MAC_PAD_EN defined: 42-byte frame -> 18 bytes of 0x00 after the data; tx_en high for 72 cycles; FCS computed over 60 bytes.
- Two 64-byte frames back-to-back -> exactly 12 idle cycles between the last FCS byte and the next 0x55.
- Continuous 1500-byte frames with din_vld every cycle -> din_rdy deasserts near full; no word lost; frame_cnt tracks correctly.
- rst asserted during DATA byte 20 -> tx_en=0 next cycle; after release, the next complete frame is transmitted cleanly with a correct FCS.
